// File: rtl/uart_receive.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered byte output with one-cycle new-data / framing-error pulses.
module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_byte_out,
  output logic       new_data_out,
  output logic       framing_err_out,
  output logic       busy_out
);

  localparam int CYCLE_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT      = CYCLE_PER_BIT / 2;
  localparam int CNT_W         = $clog2(CYCLE_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CYCLE_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             new_data_q, new_data_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rx_s_q;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_wire_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      new_data_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      new_data_q <= new_data_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    new_data_d = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at mid-start so short low glitches are rejected.
      S_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Leaving at mid-stop lets a back-to-back start bit be caught.
      S_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_byte_out   = data_q;
  assign new_data_out    = new_data_q;
  assign framing_err_out = ferr_q;
  assign busy_out        = (state_q != S_IDLE);

endmodule
